modulo_counter: RTL and testbench

//  Parametrised up/down modulo counter: runtime direction, synchronous load,

---
 rtl/modulo_counter.sv | 128 ++++++++++++
 tb/tb_modulo_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : modulo_counter                                             |
// | Description : Parametrised up/down modulo counter with runtime direction,|
// |               synchronous clamped load, wrap or one-shot mode and        |
// |               terminal-count flags. Used for FSM timeouts, baud/tick     |
// |               generation and loop indices.                               |
// | Options     : COUNTER_PRESCALE_EN - when defined, an internal prescaler  |
// |               makes the counter step once every PRESCALE enabled cycles. |
// |               Ports are identical in both builds.                        |
// | Ports       : clk      - rising-edge clock                               |
// |               reset    - asynchronous active-low reset                   |
// |               en       - count enable                                    |
// |               up       - direction, 1 = increment, 0 = decrement         |
// |               load     - synchronous load strobe (highest priority)      |
// |               load_val - value captured on load, clamped to MAXV         |
// |               oneshot  - 1 = halt at terminal value, 0 = wrap            |
// |               count    - current count (registered)                      |
// |               done     - combinational terminal-value flag               |
// |               wrap     - registered one-cycle pulse after terminal step  |
// |               halted   - registered, one-shot run has terminated         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module modulo_counter #(
   parameter int N        = 4,
   parameter int MAXV     = 2**N - 1,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         oneshot,
   output logic [N-1:0] count,
   output logic         done,
   output logic         wrap,
   output logic         halted
);

   localparam logic [N-1:0] c_maxv = N'(MAXV);

`ifdef COUNTER_PRESCALE_EN
   localparam bit c_psc_en = 1'b1;
`else
   localparam bit c_psc_en = 1'b0;
`endif

   // Elaboration-time legality checks.
   generate
      if ((MAXV < 1) || (longint'(MAXV) > ((longint'(1) << N) - 1))) begin : g_maxv_check
         $fatal(1, "modulo_counter: MAXV must satisfy 1 <= MAXV <= 2**N-1");
      end
      if (c_psc_en && (PRESCALE < 2)) begin : g_prescale_check
         $fatal(1, "modulo_counter: PRESCALE must be >= 2");
      end
   endgenerate

   logic [N-1:0] r_count;
   logic         r_wrap;
   logic         r_halted;
   logic         w_tick;
   logic         w_step;
   logic         w_term;
   logic [N-1:0] w_load_clamped;

`ifdef COUNTER_PRESCALE_EN
   localparam int                 c_psc_w    = $clog2(PRESCALE);
   localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(PRESCALE - 1);

   logic [c_psc_w-1:0] r_psc;

   // The step fires on the edge where the prescaler sits at its last phase;
   // the prescaler freezes while disabled or halted so phase is preserved.
   assign w_tick = (r_psc == c_psc_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_psc <= '0;
      end else if (load) begin
         r_psc <= '0;
      end else if (en && !r_halted) begin
         r_psc <= w_tick ? '0 : r_psc + c_psc_w'(1);
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   // Terminal detection is done by comparison, never by inspecting a carry,
   // so no overflow can occur even when MAXV == 2**N-1.
   assign w_term         = up ? (r_count == c_maxv) : (r_count == '0);
   assign w_step         = en && !r_halted && w_tick;
   assign w_load_clamped = (load_val > c_maxv) ? c_maxv : load_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count  <= '0;
         r_wrap   <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (load) begin
            r_count  <= w_load_clamped;
            r_halted <= 1'b0;
         end else if (w_step) begin
            if (w_term) begin
               r_wrap <= 1'b1;
               if (oneshot) begin
                  r_halted <= 1'b1;
               end else begin
                  r_count <= up ? '0 : c_maxv;
               end
            end else begin
               r_count <= up ? (r_count + N'(1)) : (r_count - N'(1));
            end
         end
      end
   end

   assign count  = r_count;
   assign done   = w_term;
   assign wrap   = r_wrap;
   assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_modulo_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_modulo_counter                                          |
// | Description : Directed self-checking bench for modulo_counter with       |
// |               N=4, MAXV=9, PRESCALE=4 and a 10 ns clock.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_modulo_counter;

   localparam int c_n = 4;

   logic           clk;
   logic           reset;
   logic           en;
   logic           up;
   logic           load;
   logic [c_n-1:0] load_val;
   logic           oneshot;
   logic [c_n-1:0] count;
   logic           done;
   logic           wrap;
   logic           halted;

   int n_checks;
   int n_errors;

   modulo_counter #(
      .N        (c_n),
      .MAXV     (9),
      .PRESCALE (4)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .oneshot  (oneshot),
      .count    (count),
      .done     (done),
      .wrap     (wrap),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and confirm the immediate clear.
   task automatic pulse_reset(input string tag);
      reset = 1'b0;
      #2;
      check({tag, "_count"},  32'(count),  32'd0);
      check({tag, "_wrap"},   32'(wrap),   32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      int exp_c;
      n_checks = 0;
      n_errors = 0;

      reset    = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      oneshot  = 1'b0;

      // Test 1: reset state, then up-count 0..9,0,1
      #10;
      check("rst_count",  32'(count),  32'd0);
      check("rst_wrap",   32'(wrap),   32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_done",   32'(done),   32'd0);
      #10;
      reset = 1'b1;
      en    = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         exp_c = i % 10;
         check("up_count", 32'(count), 32'(exp_c));
         check("up_done",  32'(done),  32'(exp_c == 9));
         check("up_wrap",  32'(wrap),  32'(exp_c == 0));
      end

      // Test 2: reset, then down-count 0,9,...,0,9
      up = 1'b0;
      pulse_reset("rst2");
      check("dn_done0", 32'(done), 32'd1);
      for (int i = 1; i <= 11; i++) begin
         tick();
         exp_c = (10 - (i % 10)) % 10;
         check("dn_count", 32'(count), 32'(exp_c));
         check("dn_done",  32'(done),  32'(exp_c == 0));
         check("dn_wrap",  32'(wrap),  32'(exp_c == 9));
      end

      // Test 3: load 7, one-shot up to halt at 9
      en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd7;
      tick();
      check("ld7_count", 32'(count), 32'd7);
      load = 1'b0; en = 1'b1; oneshot = 1'b1;
      tick();
      check("os_count8", 32'(count), 32'd8);
      tick();
      check("os_count9",  32'(count),  32'd9);
      check("os_wrap9",   32'(wrap),   32'd0);
      check("os_halted9", 32'(halted), 32'd0);
      tick();
      check("os_term_count",  32'(count),  32'd9);
      check("os_term_wrap",   32'(wrap),   32'd1);
      check("os_term_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            up      = 1'b0;
            oneshot = 1'b0;
         end
         tick();
         check("hold_count",  32'(count),  32'd9);
         check("hold_wrap",   32'(wrap),   32'd0);
         check("hold_halted", 32'(halted), 32'd1);
      end
      up = 1'b1; oneshot = 1'b0; load = 1'b1; load_val = 4'd3;
      tick();
      check("ld3_count",  32'(count),  32'd3);
      check("ld3_halted", 32'(halted), 32'd0);
      load = 1'b0;
      tick();
      check("resume_count", 32'(count), 32'd4);

      // Test 4: clamped load, and load overriding a terminal step
      load = 1'b1; load_val = 4'd12;
      tick();
      check("clamp_count", 32'(count), 32'd9);
      check("clamp_wrap",  32'(wrap),  32'd0);
      load_val = 4'd5;
      tick();
      check("ldterm_count", 32'(count), 32'd5);
      check("ldterm_wrap",  32'(wrap),  32'd0);
      load = 1'b0;
      tick();
      check("post_ld_count", 32'(count), 32'd6);

      // Test 5: asynchronous reset mid-count, and while halted with wrap high
      load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("pre_rst5_count", 32'(count), 32'd5);
      pulse_reset("rst5");
      tick();
      check("rst5_resume", 32'(count), 32'd1);
      load = 1'b1; load_val = 4'd9; oneshot = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check("pre_rst5b_wrap",   32'(wrap),   32'd1);
      check("pre_rst5b_halted", 32'(halted), 32'd1);
      oneshot = 1'b0;
      pulse_reset("rst5b");
      tick();
      check("rst5b_resume", 32'(count), 32'd1);

`ifdef COUNTER_PRESCALE_EN
      // Test 6: prescaled stepping with a mid-period enable gap
      pulse_reset("rst6");
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("psc_count", 32'(count), 32'(i / 4));
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("psc_gap_count", 32'(count), 32'd2);
      end
      en = 1'b1;
      tick();
      check("psc_phase11", 32'(count), 32'd2);
      tick();
      check("psc_phase12", 32'(count), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
